// File: rtl/enemy_spawn_scheduler.sv
// rtl/enemy_spawn_scheduler.sv - enemy car slot pool scheduler for the race game
// Spawns cars into free slots on lanes picked by an LFSR, recycles slots on exit, tracks passes and speed.
module enemy_spawn_scheduler #(
  parameter int          NUM_SLOTS      = 3,
  parameter logic [9:0]  LANE_X0        = 10'd160,
  parameter logic [9:0]  LANE_PITCH     = 10'd100,
  parameter logic [9:0]  PARK_X         = 10'd640,
  parameter logic [9:0]  EXIT_Y         = 10'd600,
  parameter logic [7:0]  SPAWN_GAP      = 8'd90,
  parameter logic [7:0]  LEVEL_UP_COUNT = 8'd8,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                    logic_clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    collision,
  input  logic [10*NUM_SLOTS-1:0] enemy_pos_y,
  output logic [10*NUM_SLOTS-1:0] enemy_offset_x,
  output logic [NUM_SLOTS-1:0]    enemy_reset,
  output logic [NUM_SLOTS-1:0]    enemy_active,
  output logic [2:0]              speed_level,
  output logic [7:0]              cars_passed,
  output logic [1:0]              game_state
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_CRASH = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic [NUM_SLOTS-1:0]    active_q, active_d;
  logic [NUM_SLOTS-1:0]    park_q, park_d;
  logic [10*NUM_SLOTS-1:0] offset_q, offset_d;
  logic [2:0]              speed_q, speed_d;
  logic [7:0]              cars_q, cars_d;
  logic [7:0]              timer_q, timer_d;
  logic [1:0]              last_lane_q, last_lane_d;
  logic [15:0]             lfsr_q, lfsr_d;

  logic [3:0] exit_cnt;
  logic [8:0] cars_sum;
  logic [7:0] gap;
  logic [1:0] lane;
  logic [9:0] lane_x;
  logic       spawn_done;

  always_ff @(posedge logic_clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      active_q    <= '0;
      park_q      <= '1;
      offset_q    <= {NUM_SLOTS{PARK_X}};
      speed_q     <= 3'd0;
      cars_q      <= 8'd0;
      timer_q     <= 8'd0;
      last_lane_q <= 2'd0;
      lfsr_q      <= LFSR_SEED;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      park_q      <= park_d;
      offset_q    <= offset_d;
      speed_q     <= speed_d;
      cars_q      <= cars_d;
      timer_q     <= timer_d;
      last_lane_q <= last_lane_d;
      lfsr_q      <= lfsr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    park_d      = park_q;
    offset_d    = offset_q;
    speed_d     = speed_q;
    cars_d      = cars_q;
    timer_d     = timer_q;
    last_lane_d = last_lane_q;
    lfsr_d      = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    exit_cnt    = 4'd0;
    cars_sum    = 9'd0;
    spawn_done  = 1'b0;
    gap         = SPAWN_GAP - {2'b00, speed_q, 3'b000};
    // Never repeat the previous lane so consecutive cars cannot stack.
    lane        = (lfsr_q[1:0] == last_lane_q) ? lfsr_q[1:0] + 2'd1 : lfsr_q[1:0];
    lane_x      = LANE_X0 + LANE_PITCH * {8'd0, lane};

    case (state_q)
      ST_IDLE: begin
        active_d = '0;
        park_d   = '1;
        offset_d = {NUM_SLOTS{PARK_X}};
        timer_d  = 8'd0;
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (collision) begin
          state_d = ST_CRASH;
        end else begin
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (active_q[i] && (enemy_pos_y[10*i +: 10] >= EXIT_Y)) begin
              active_d[i]          = 1'b0;
              park_d[i]            = 1'b1;
              offset_d[10*i +: 10] = PARK_X;
              exit_cnt             = exit_cnt + 4'd1;
            end
          end
          // Eligibility uses registered active, so a slot freed this cycle waits one more.
          if (timer_q != 8'd0) begin
            timer_d = timer_q - 8'd1;
          end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
              if (!spawn_done && !active_q[i]) begin
                spawn_done           = 1'b1;
                active_d[i]          = 1'b1;
                park_d[i]            = 1'b0;
                offset_d[10*i +: 10] = lane_x;
              end
            end
            if (spawn_done) begin
              last_lane_d = lane;
              timer_d     = gap - 8'd1;
            end
          end
          cars_sum = {1'b0, cars_q} + {5'd0, exit_cnt};
          cars_d   = cars_sum[8] ? 8'd255 : cars_sum[7:0];
          if ((cars_d / LEVEL_UP_COUNT != cars_q / LEVEL_UP_COUNT) && (speed_q != 3'd7))
            speed_d = speed_q + 3'd1;
        end
      end
      ST_CRASH: begin
        if (start) begin
          state_d     = ST_IDLE;
          active_d    = '0;
          park_d      = '1;
          offset_d    = {NUM_SLOTS{PARK_X}};
          speed_d     = 3'd0;
          cars_d      = 8'd0;
          timer_d     = 8'd0;
          last_lane_d = 2'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign enemy_offset_x = offset_q;
  assign enemy_reset    = park_q;
  assign enemy_active   = active_q;
  assign speed_level    = speed_q;
  assign cars_passed    = cars_q;
  assign game_state     = state_q;

endmodule

// File: tb/tb_enemy_spawn_scheduler.sv
// tb/tb_enemy_spawn_scheduler.sv - directed self-checking bench for enemy_spawn_scheduler
module tb_enemy_spawn_scheduler;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        logic_clk = 1'b0;
  logic        reset, start, collision;
  logic [29:0] enemy_pos_y;
  logic [29:0] enemy_offset_x;
  logic [2:0]  enemy_reset, enemy_active, speed_level;
  logic [7:0]  cars_passed;
  logic [1:0]  game_state;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] m_lfsr, prev_lfsr;
  logic [1:0]  m_last;
  int          m_cars, m_speed, gap_exp, n;

  enemy_spawn_scheduler dut (
    .logic_clk      (logic_clk),
    .reset          (reset),
    .start          (start),
    .collision      (collision),
    .enemy_pos_y    (enemy_pos_y),
    .enemy_offset_x (enemy_offset_x),
    .enemy_reset    (enemy_reset),
    .enemy_active   (enemy_active),
    .speed_level    (speed_level),
    .cars_passed    (cars_passed),
    .game_state     (game_state)
  );

  always #5 logic_clk = ~logic_clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    prev_lfsr = m_lfsr;
    @(posedge logic_clk);
    m_lfsr = reset ? SEED : lfsr_next(m_lfsr);
    @(negedge logic_clk);
  endtask

  task automatic check_spawn(input int slot);
    logic [1:0] ln;
    ln = prev_lfsr[1:0];
    if (ln == m_last) ln = ln + 2'd1;
    chk("spawn_x", {22'd0, enemy_offset_x[10*slot +: 10]}, 160 + 100 * ln);
    m_last = ln;
  endtask

  task automatic wait_spawn(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (enemy_active == 3'b000 && cnt < 300);
    chk("spawn_in_time", {31'd0, cnt < 300}, 1);
  endtask

  task automatic chk_parked(input string tag);
    chk({tag, "_state"}, game_state, 0);
    chk({tag, "_active"}, enemy_active, 0);
    chk({tag, "_ereset"}, enemy_reset, 3'b111);
    chk({tag, "_offx"}, enemy_offset_x, {10'd640, 10'd640, 10'd640});
    chk({tag, "_speed"}, speed_level, 0);
    chk({tag, "_cars"}, cars_passed, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; collision = 1'b0; enemy_pos_y = '0;
    m_lfsr = '0; prev_lfsr = '0; m_last = 2'd0; m_cars = 0; m_speed = 0;
    tick(); tick();
    reset = 1'b0;
    chk_parked("reset");

    // First spawn one edge after entering RUN
    start = 1'b1; tick(); start = 1'b0;
    chk("run_state", game_state, 1);
    chk("run_active", enemy_active, 0);
    tick();
    chk("spawn0_active", enemy_active, 3'b001);
    chk("spawn0_ereset", enemy_reset, 3'b110);
    check_spawn(0);
    chk("spawn0_others", enemy_offset_x[29:10], {10'd640, 10'd640});

    // Spawns exactly 90 cycles apart
    repeat (89) tick();
    chk("gap_hold1", enemy_active, 3'b001);
    tick();
    chk("spawn1_active", enemy_active, 3'b011);
    check_spawn(1);
    repeat (89) tick();
    chk("gap_hold2", enemy_active, 3'b011);
    tick();
    chk("spawn2_active", enemy_active, 3'b111);
    check_spawn(2);
    repeat (100) tick();
    chk("full_active", enemy_active, 3'b111);

    // Exit on slot1; respawn one cycle later
    enemy_pos_y[19:10] = 10'd600; tick(); enemy_pos_y = '0;
    chk("exit_active", enemy_active, 3'b101);
    chk("exit_ereset", enemy_reset, 3'b010);
    chk("exit_offx1", enemy_offset_x[19:10], 640);
    chk("exit_cars", cars_passed, 1);
    tick();
    chk("respawn_active", enemy_active, 3'b111);
    chk("respawn_ereset", enemy_reset, 3'b000);
    check_spawn(1);
    m_cars = 1;

    // Triple exit, then every car exits the cycle after it spawns
    enemy_pos_y = {10'd600, 10'd600, 10'd600};
    tick();
    m_cars += 3;
    chk("multi_exit_active", enemy_active, 0);
    chk("multi_exit_cars", cars_passed, m_cars);
    wait_spawn(n);
    chk("first_wait", n, 89);
    chk("loop_spawn_slot", enemy_active, 3'b001);
    check_spawn(0);
    gap_exp = 90;
    for (int k = 0; k < 60; k++) begin
      tick();
      m_cars++;
      m_speed = (m_cars / 8 > 7) ? 7 : m_cars / 8;
      chk("loop_cars", cars_passed, m_cars);
      chk("loop_speed", speed_level, m_speed);
      wait_spawn(n);
      chk("loop_gap", n + 1, gap_exp);
      check_spawn(0);
      gap_exp = 90 - 8 * m_speed;
    end
    chk("speed_sat", speed_level, 7);

    // Collision during exit cycle freezes everything
    collision = 1'b1; tick(); collision = 1'b0;
    chk("crash_state", game_state, 2);
    chk("crash_active", enemy_active, 3'b001);
    chk("crash_cars", cars_passed, m_cars);
    repeat (100) tick();
    chk("frozen_state", game_state, 2);
    chk("frozen_active", enemy_active, 3'b001);
    chk("frozen_ereset", enemy_reset, 3'b110);
    chk("frozen_offx0", enemy_offset_x[9:0], 160 + 100 * m_last);
    chk("frozen_offx_hi", enemy_offset_x[29:10], {10'd640, 10'd640});
    chk("frozen_cars", cars_passed, m_cars);
    chk("frozen_speed", speed_level, 7);
    start = 1'b1; tick(); start = 1'b0;
    m_last = 2'd0;
    chk_parked("restart");

    // Mid-game reset with all slots active
    enemy_pos_y = '0;
    start = 1'b1; tick();
    chk("run2_state", game_state, 1);
    tick(); start = 1'b0;
    chk("start_ignored", game_state, 1);
    check_spawn(0);
    repeat (90) tick();
    check_spawn(1);
    repeat (90) tick();
    chk("run2_full", enemy_active, 3'b111);
    check_spawn(2);
    reset = 1'b1; tick(); reset = 1'b0;
    m_last = 2'd0;
    chk_parked("midreset");
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("post_reset_spawn", enemy_active, 3'b001);
    check_spawn(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
